// File: rtl/noc_arb_pkg.sv
// Shared arbitration helpers: one-hot/index conversion and the idle owner encoding.
// Also used by the allocator, so widths are sized for the largest supported port count.
package noc_arb_pkg;

  localparam int unsigned MaxPorts = 32;
  localparam int unsigned MaxIdxW  = 5;

  typedef logic [MaxPorts-1:0] port_vec_t;
  typedef logic [MaxIdxW-1:0]  port_idx_t;

  // An all-zero owner vector means no port holds the output.
  localparam port_vec_t OwnerIdle = '0;

  typedef enum logic [1:0] {
    PhIdle,
    PhArm,
    PhSend
  } arb_phase_e;

  function automatic port_idx_t onehot2idx(port_vec_t oh);
    port_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < MaxPorts; i++) begin
      if (oh[i]) idx = idx | port_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic port_vec_t idx2onehot(port_idx_t idx);
    port_vec_t oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/noc_rr_arbiter_if.sv
// Requester/downstream handshake bundle for one router output port.
interface noc_rr_arbiter_if #(
  parameter int unsigned NUM_PORTS = 5
) ();

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] last;
  logic                 dcts;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] xbar_sel;
  logic                 rts;
  logic                 locked;

  modport master (
    output req,
    output last,
    output dcts,
    input  grant,
    input  xbar_sel,
    input  rts,
    input  locked
  );

  modport slave (
    input  req,
    input  last,
    input  dcts,
    output grant,
    output xbar_sel,
    output rts,
    output locked
  );

endinterface

// File: rtl/noc_rr_pick.sv
// Combinational rotating priority encoder: first requester after start_idx, wrapping,
// with start_idx itself checked last.
module noc_rr_pick #(
  parameter int unsigned NUM_PORTS = 5
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] start_idx,
  output logic [NUM_PORTS-1:0]         onehot,
  output logic                         valid
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  logic [IdxW-1:0] idx;

  always_comb begin
    onehot = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = IdxW'((32'(start_idx) + i) % NUM_PORTS);
      if (!valid && req[idx]) begin
        onehot[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_rr_arbiter.sv
// Output-port arbiter: rotating priority with wormhole lock, per-owner packet cap and
// RTS/DCTS flit handshake toward the downstream router.
module noc_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned MAX_PKTS  = 4
) (
  input logic             clk,
  input logic             rst,
  noc_rr_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);
  localparam int unsigned CntW = $clog2(MAX_PKTS + 1);

  logic [NUM_PORTS-1:0] owner_q;
  logic                 rts_q;
  logic                 lock_q;
  logic [IdxW-1:0]      last_idx_q;
  logic [CntW-1:0]      pkt_cnt_q;

  logic [IdxW-1:0]      owner_idx;
  logic [IdxW-1:0]      pick_start;
  logic [NUM_PORTS-1:0] pick_oh;
  logic                 pick_valid;
  logic                 owner_live;
  logic                 owner_tail;
  logic                 xfer;
  arb_phase_e           phase;

  assign owner_idx  = IdxW'(onehot2idx(port_vec_t'(owner_q)));
  assign owner_live = |(owner_q & bus.req);
  assign owner_tail = |(owner_q & bus.last);
  // Reset wins over a pending transfer so no flit leaves while rst is sampled.
  assign xfer       = rts_q & bus.dcts & ~rst;

  // After a transfer the rotation must start from the port just served, not the stale index.
  assign pick_start = xfer ? owner_idx : last_idx_q;

  always_comb begin
    phase = PhIdle;
    if (owner_q != NUM_PORTS'(OwnerIdle)) begin
      phase = rts_q ? PhSend : PhArm;
    end
  end

  noc_rr_pick #(
    .NUM_PORTS(NUM_PORTS)
  ) u_pick (
    .req      (bus.req),
    .start_idx(pick_start),
    .onehot   (pick_oh),
    .valid    (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= '0;
      rts_q      <= 1'b0;
      lock_q     <= 1'b0;
      last_idx_q <= IdxW'(NUM_PORTS - 1);
      pkt_cnt_q  <= '0;
    end else begin
      unique case (phase)
        PhIdle: begin
          if (pick_valid) begin
            owner_q   <= pick_oh;
            pkt_cnt_q <= '0;
          end
        end
        PhArm: begin
          if (owner_live) begin
            rts_q <= 1'b1;
          end else if (!lock_q) begin
            // Owner withdrew between packets: hand over, or fall to idle if nobody asks.
            owner_q   <= pick_oh;
            pkt_cnt_q <= '0;
          end
        end
        PhSend: begin
          if (bus.dcts) begin
            rts_q      <= 1'b0;
            last_idx_q <= owner_idx;
            if (!owner_tail) begin
              lock_q <= 1'b1;
            end else begin
              lock_q <= 1'b0;
              if (owner_live && (pkt_cnt_q < CntW'(MAX_PKTS - 1))) begin
                pkt_cnt_q <= pkt_cnt_q + CntW'(1);
              end else begin
                owner_q   <= pick_oh;
                pkt_cnt_q <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.grant    = xfer ? owner_q : '0;
  assign bus.xbar_sel = owner_q;
  assign bus.rts      = rts_q;
  assign bus.locked   = lock_q;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Randomised and directed bench for noc_rr_arbiter; three instances with different packet
// caps share one stimulus stream and are each compared against a behavioural model.
module tb_noc_rr_arbiter;

  localparam int unsigned N     = 5;
  localparam int          NInst = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] last;
  logic         dcts;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  noc_rr_arbiter_if #(.NUM_PORTS(N)) bus0 ();
  noc_rr_arbiter_if #(.NUM_PORTS(N)) bus1 ();
  noc_rr_arbiter_if #(.NUM_PORTS(N)) bus2 ();

  assign bus0.req  = req;
  assign bus0.last = last;
  assign bus0.dcts = dcts;
  assign bus1.req  = req;
  assign bus1.last = last;
  assign bus1.dcts = dcts;
  assign bus2.req  = req;
  assign bus2.last = last;
  assign bus2.dcts = dcts;

  noc_rr_arbiter #(.NUM_PORTS(N), .MAX_PKTS(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  noc_rr_arbiter #(.NUM_PORTS(N), .MAX_PKTS(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  noc_rr_arbiter #(.NUM_PORTS(N), .MAX_PKTS(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Reference state: owner as a port number (-1 = nobody), plain integer counters.
  int m_owner [NInst];
  bit m_rts   [NInst];
  bit m_lock  [NInst];
  int m_last  [NInst];
  int m_cnt   [NInst];
  int m_max   [NInst] = '{1, 2, 4};

  logic [N-1:0] s_grant [NInst];
  logic [N-1:0] s_xbar  [NInst];
  logic         s_rts   [NInst];
  logic         s_lock  [NInst];

  int gq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick_ref(input int start, input logic [N-1:0] r);
    for (int i = 1; i <= N; i++) begin
      int p;
      p = (start + i) % N;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] vec_of(input int idx);
    logic [N-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input int k);
    int o;
    o = m_owner[k];
    if (rst) begin
      m_owner[k] = -1;
      m_rts[k]   = 1'b0;
      m_lock[k]  = 1'b0;
      m_last[k]  = N - 1;
      m_cnt[k]   = 0;
    end else if (o < 0) begin
      if (req != '0) begin
        m_owner[k] = pick_ref(m_last[k], req);
        m_cnt[k]   = 0;
      end
    end else if (!m_rts[k]) begin
      if (req[o]) m_rts[k] = 1'b1;
      else if (!m_lock[k]) begin
        m_owner[k] = pick_ref(m_last[k], req);
        m_cnt[k]   = 0;
      end
    end else if (dcts) begin
      m_rts[k]  = 1'b0;
      m_last[k] = o;
      if (!last[o]) m_lock[k] = 1'b1;
      else begin
        m_lock[k] = 1'b0;
        if (req[o] && m_cnt[k] < m_max[k] - 1) m_cnt[k]++;
        else begin
          m_owner[k] = pick_ref(o, req);
          m_cnt[k]   = 0;
        end
      end
    end
  endtask

  // One clock: sample at negedge, compare all instances to the model, advance, then settle.
  task automatic cycle();
    logic [N-1:0] eg;
    @(negedge clk);
    s_grant[0] = bus0.grant; s_xbar[0] = bus0.xbar_sel; s_rts[0] = bus0.rts; s_lock[0] = bus0.locked;
    s_grant[1] = bus1.grant; s_xbar[1] = bus1.xbar_sel; s_rts[1] = bus1.rts; s_lock[1] = bus1.locked;
    s_grant[2] = bus2.grant; s_xbar[2] = bus2.xbar_sel; s_rts[2] = bus2.rts; s_lock[2] = bus2.locked;
    for (int k = 0; k < NInst; k++) begin
      eg = (m_rts[k] && dcts && !rst) ? vec_of(m_owner[k]) : '0;
      check($sformatf("i%0d_grant", k), 32'(s_grant[k]), 32'(eg));
      check($sformatf("i%0d_xbar", k), 32'(s_xbar[k]), 32'(vec_of(m_owner[k])));
      check($sformatf("i%0d_rts", k), 32'(s_rts[k]), 32'(m_rts[k]));
      check($sformatf("i%0d_locked", k), 32'(s_lock[k]), 32'(m_lock[k]));
    end
    for (int k = 0; k < NInst; k++) model_step(k);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    last = '0;
    dcts = 1'b0;
    for (int k = 0; k < NInst; k++) model_step(k);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic collect(input int k, input int n);
    gq.delete();
    for (int c = 0; c < 80 && gq.size() < n; c++) begin
      cycle();
      if (s_grant[k] != '0) gq.push_back(idx_of(s_grant[k]));
    end
    check($sformatf("collect_i%0d_count", k), 32'(gq.size()), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_rot[4];
    int exp_cap[6];
    int flits;
    int drop;
    bit dropping;
    bit p3_done;

    // Reset state
    do_reset();
    cycle();
    check("rst_xbar", 32'(s_xbar[2]), 32'h0);
    check("rst_rts", 32'(s_rts[2]), 32'h0);
    check("rst_grant", 32'(s_grant[2]), 32'h0);
    check("rst_locked", 32'(s_lock[2]), 32'h0);

    // Idle-to-grant latency
    req  = 5'b00001;
    last = 5'b11111;
    dcts = 1'b1;
    cycle();
    cycle();
    check("lat_xbar_t1", 32'(s_xbar[2]), 32'h01);
    check("lat_rts_t1", 32'(s_rts[2]), 32'h0);
    cycle();
    check("lat_rts_t2", 32'(s_rts[2]), 32'h1);
    check("lat_grant_t2", 32'(s_grant[2]), 32'h01);
    cycle();
    check("lat_rts_t3", 32'(s_rts[2]), 32'h0);

    // Rotation with a cap of one packet
    do_reset();
    req  = 5'b10110;
    last = 5'b11111;
    dcts = 1'b1;
    exp_rot = '{1, 2, 4, 1};
    collect(0, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rot_%0d", i), 32'(i < gq.size() ? gq[i] : -1), 32'(exp_rot[i]));
    end

    // Cap of two packets, two requesters, then a sole requester
    do_reset();
    req  = 5'b00011;
    last = 5'b11111;
    dcts = 1'b1;
    exp_cap = '{0, 0, 1, 1, 0, 0};
    collect(1, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("cap_%0d", i), 32'(i < gq.size() ? gq[i] : -1), 32'(exp_cap[i]));
    end
    do_reset();
    req  = 5'b00001;
    last = 5'b11111;
    dcts = 1'b1;
    collect(1, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sole_%0d", i), 32'(i < gq.size() ? gq[i] : -1), 32'h0);
    end

    // Wormhole lock: port 2 sends three flits, pauses mid-packet, port 3 waits
    do_reset();
    dcts    = 1'b1;
    flits   = 0;
    drop    = 0;
    p3_done = 1'b0;
    for (int c = 0; c < 80 && !p3_done; c++) begin
      dropping = (drop > 0);
      req      = 5'b01000;
      req[2]   = (flits < 3) && !dropping;
      last     = 5'b11011;
      last[2]  = (flits == 2);
      cycle();
      check("lock_no_p3_early", 32'(s_grant[2][3] && flits < 3), 32'h0);
      if (dropping) begin
        check("lock_drop_rts", 32'(s_rts[2]), 32'h0);
        check("lock_drop_xbar", 32'(s_xbar[2]), 32'h04);
        check("lock_drop_locked", 32'(s_lock[2]), 32'h1);
        drop--;
      end
      if (s_grant[2][2]) begin
        flits++;
        if (flits == 1) drop = 2;
      end
      if (s_grant[2][3]) p3_done = 1'b1;
    end
    check("lock_p2_flits", 32'(flits), 32'd3);
    check("lock_p3_served", 32'(p3_done), 32'h1);

    // Downstream back-pressure
    do_reset();
    req  = 5'b00001;
    last = 5'b11111;
    dcts = 1'b0;
    cycle();
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_rts", 32'(s_rts[2]), 32'h1);
      check("bp_grant", 32'(s_grant[2]), 32'h0);
      check("bp_xbar", 32'(s_xbar[2]), 32'h01);
    end
    dcts = 1'b1;
    cycle();
    check("bp_release_grant", 32'(s_grant[2]), 32'h01);
    cycle();
    check("bp_after_rts", 32'(s_rts[2]), 32'h0);

    // Reset in the middle of a locked packet
    do_reset();
    req  = 5'b00001;
    last = 5'b00000;
    dcts = 1'b1;
    for (int c = 0; c < 20 && !(m_rts[2] && m_lock[2]); c++) cycle();
    rst = 1'b1;
    cycle();
    check("mid_rst_pre_rts", 32'(s_rts[2]), 32'h1);
    check("mid_rst_pre_locked", 32'(s_lock[2]), 32'h1);
    check("mid_rst_grant", 32'(s_grant[2]), 32'h0);
    rst  = 1'b0;
    req  = 5'b11111;
    last = 5'b11111;
    cycle();
    check("mid_rst_xbar", 32'(s_xbar[2]), 32'h0);
    check("mid_rst_rts", 32'(s_rts[2]), 32'h0);
    check("mid_rst_locked", 32'(s_lock[2]), 32'h0);
    check("mid_rst_grant_after", 32'(s_grant[2]), 32'h0);
    cycle();
    check("mid_rst_prio_p0", 32'(s_xbar[2]), 32'h01);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 500; c++) begin
      req  = N'($urandom);
      last = N'($urandom);
      dcts = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
